noc_inject_arb: RTL and testbench

Round-robin injection arbiter that shares one NoC router input port between `N_REQ` traffic sources. It accepts flits on per-requester valid/ready channels and registers the winner into a one-flit output stage driving the router port. It enforces an optional per-requester flit budget and asserts `done` once every budget is exhausted. It sits between the source BFMs and the router they share.

---
 rtl/noc_inject_arb.sv | 110 +++++++++++
 tb/tb_noc_inject_arb.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/noc_inject_arb.sv
// Round-robin injection arbiter: N_REQ valid/ready sources share one router input
// through a single registered flit stage, with optional per-source flit budgets.
module noc_inject_arb #(
  parameter int WIDTH        = 32,
  parameter int N            = 16,
  parameter int N_ADDR_WIDTH = $clog2(N),
  parameter int N_REQ        = 4,
  parameter int REQ_W        = $clog2(N_REQ),
  parameter int BUDGET       = 1000,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [N_REQ-1:0]              valid_in,
  input  logic [N_REQ*WIDTH-1:0]        data_in,
  input  logic [N_REQ*N_ADDR_WIDTH-1:0] dest_in,
  output logic [N_REQ-1:0]              ready_out,
  output logic [WIDTH-1:0]              data_out,
  output logic [N_ADDR_WIDTH-1:0]       dest_out,
  output logic                          valid_out,
  input  logic                          ready_in,
  output logic [REQ_W-1:0]              src_out,
  output logic [CNT_WIDTH-1:0]          total_count,
  output logic                          done
);

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [CNT_WIDTH-1:0] BUDGET_C = CNT_WIDTH'(BUDGET);

  logic [CNT_WIDTH-1:0]    cnt      [N_REQ];
  logic [WIDTH-1:0]        data_arr [N_REQ];
  logic [N_ADDR_WIDTH-1:0] dest_arr [N_REQ];
  logic [N_REQ-1:0]        eligible;
  logic [REQ_W-1:0]        rr_ptr;
  logic [REQ_W-1:0]        grant;
  logic [REQ_W-1:0]        idx;
  int                      sum;
  logic                    found;
  logic                    can_load;
  logic                    load;
  logic                    drain;
  logic                    all_spent;

  for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
    assign data_arr[g] = data_in[g*WIDTH +: WIDTH];
    assign dest_arr[g] = dest_in[g*N_ADDR_WIDTH +: N_ADDR_WIDTH];
    assign eligible[g] = valid_in[g] && ((BUDGET == 0) || (cnt[g] < BUDGET_C));
  end

  // Search starts at rr_ptr and wraps, so the last winner becomes lowest priority.
  always_comb begin
    found = 1'b0;
    grant = '0;
    idx   = '0;
    sum   = 0;
    for (int k = 0; k < N_REQ; k++) begin
      sum = int'(rr_ptr) + k;
      if (sum >= N_REQ) sum = sum - N_REQ;
      idx = REQ_W'(sum);
      if (!found && eligible[idx]) begin
        found = 1'b1;
        grant = idx;
      end
    end
  end

  assign can_load = !valid_out || ready_in;
  assign drain    = valid_out && ready_in;
  assign load     = found && can_load && !rst;

  always_comb begin
    ready_out = '0;
    if (load) ready_out[grant] = 1'b1;
  end

  always_comb begin
    all_spent = (BUDGET != 0);
    for (int i = 0; i < N_REQ; i++) begin
      if (cnt[i] != BUDGET_C) all_spent = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_out   <= 1'b0;
      data_out    <= '0;
      dest_out    <= '0;
      src_out     <= '0;
      total_count <= '0;
      done        <= 1'b0;
      rr_ptr      <= '0;
      for (int i = 0; i < N_REQ; i++) cnt[i] <= '0;
    end else begin
      if (load) begin
        data_out  <= data_arr[grant];
        dest_out  <= dest_arr[grant];
        src_out   <= grant;
        valid_out <= 1'b1;
        if (cnt[grant] != CNT_MAX) cnt[grant] <= cnt[grant] + 1'b1;
        rr_ptr    <= (grant == REQ_W'(N_REQ - 1)) ? '0 : grant + 1'b1;
      end else if (drain) begin
        valid_out <= 1'b0;
      end
      if (drain && (total_count != CNT_MAX)) total_count <= total_count + 1'b1;
      // done only rises once the last budgeted flit has left the output stage.
      if (all_spent && !valid_out) done <= 1'b1;
    end
  end

endmodule

// File: tb/tb_noc_inject_arb.sv
// Scoreboard bench for noc_inject_arb: a 4-source unlimited-budget instance checked
// against a queue-based model, plus a 2-source BUDGET=3 instance for budget/done.
module tb_noc_inject_arb;

  localparam int WIDTH = 32;
  localparam int AW    = 4;
  localparam int NR    = 4;
  localparam int RW    = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst;
  logic [NR-1:0]        valid_in;
  logic [NR*WIDTH-1:0]  data_in;
  logic [NR*AW-1:0]     dest_in;
  logic [NR-1:0]        ready_out;
  logic [WIDTH-1:0]     data_out;
  logic [AW-1:0]        dest_out;
  logic                 valid_out;
  logic                 ready_in;
  logic [RW-1:0]        src_out;
  logic [15:0]          total_count;
  logic                 done;

  logic                 rst_b;
  logic [1:0]           valid_in_b;
  logic [15:0]          data_in_b;
  logic [3:0]           dest_in_b;
  logic [1:0]           ready_out_b;
  logic [7:0]           data_out_b;
  logic [1:0]           dest_out_b;
  logic                 valid_out_b;
  logic                 ready_in_b;
  logic                 src_out_b;
  logic [1:0]           total_count_b;
  logic                 done_b;

  noc_inject_arb #(
    .WIDTH(WIDTH), .N(16), .N_REQ(NR), .BUDGET(0), .CNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .data_in(data_in), .dest_in(dest_in),
    .ready_out(ready_out), .data_out(data_out), .dest_out(dest_out),
    .valid_out(valid_out), .ready_in(ready_in), .src_out(src_out),
    .total_count(total_count), .done(done)
  );

  noc_inject_arb #(
    .WIDTH(8), .N(4), .N_REQ(2), .BUDGET(3), .CNT_WIDTH(2)
  ) dut_b (
    .clk(clk), .rst(rst_b), .valid_in(valid_in_b), .data_in(data_in_b), .dest_in(dest_in_b),
    .ready_out(ready_out_b), .data_out(data_out_b), .dest_out(dest_out_b),
    .valid_out(valid_out_b), .ready_in(ready_in_b), .src_out(src_out_b),
    .total_count(total_count_b), .done(done_b)
  );

  typedef struct {
    logic [WIDTH-1:0] d;
    logic [AW-1:0]    a;
    logic [RW-1:0]    s;
  } flit_t;

  flit_t sb[$];
  int    m_rr;
  bit    m_full;
  int    m_total;
  int    checks   = 0;
  int    failures = 0;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bus cycle on the 4-source instance: drive, check at negedge, then advance the model.
  task automatic applyStimulus(input logic r, input logic [NR-1:0] v, input logic rdy,
                               input logic [NR*WIDTH-1:0] d, input logic [NR*AW-1:0] a);
    int g;
    bit drn;
    logic [NR-1:0] exp_ro;
    rst = r; valid_in = v; ready_in = rdy; data_in = d; dest_in = a;
    g = -1;
    if (!r && (!m_full || rdy)) begin
      for (int k = 0; k < NR; k++) begin
        if (g < 0 && v[(m_rr + k) % NR]) g = (m_rr + k) % NR;
      end
    end
    exp_ro = '0;
    if (g >= 0) exp_ro[g] = 1'b1;
    @(negedge clk);
    checkOutput("ready_out", 64'(ready_out), 64'(exp_ro));
    checkOutput("valid_out", 64'(valid_out), 64'(m_full));
    checkOutput("total_count", 64'(total_count), 64'(m_total));
    checkOutput("done_unlimited", 64'(done), 64'd0);
    @(posedge clk);
    if (r) begin
      m_rr = 0; m_full = 1'b0; m_total = 0;
      sb.delete();
    end else begin
      drn = m_full && rdy;
      if (drn && m_total < 65535) m_total++;
      if (g >= 0) begin
        sb.push_back('{d: d[g*WIDTH +: WIDTH], a: a[g*AW +: AW], s: RW'(g)});
        m_rr   = (g + 1) % NR;
        m_full = 1'b1;
      end else if (drn) begin
        m_full = 1'b0;
      end
    end
    #1;
  endtask

  function automatic logic [NR*WIDTH-1:0] rand_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic [NR*AW-1:0] rand_dest();
    logic [31:0] t;
    t = $urandom;
    return t[NR*AW-1:0];
  endfunction

  // Monitor: every flit the router accepts must match the oldest scoreboard entry.
  initial begin
    flit_t e;
    forever begin
      @(negedge clk);
      if (rst === 1'b0 && valid_out === 1'b1 && ready_in === 1'b1) begin
        if (sb.size() == 0) begin
          checkOutput("sb_underflow", 64'd1, 64'd0);
        end else begin
          e = sb.pop_front();
          checkOutput("data_out", 64'(data_out), 64'(e.d));
          checkOutput("dest_out", 64'(dest_out), 64'(e.a));
          checkOutput("src_out", 64'(src_out), 64'(e.s));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired checks=%0d", checks);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    logic [NR*WIDTH-1:0] d;
    logic [NR*AW-1:0]    a;
    int grants_b[2];
    int drains_b;
    int last_b;
    bit exp_done;

    m_rr = 0; m_full = 1'b0; m_total = 0;
    rst = 1'b1; valid_in = 4'b1111; ready_in = 1'b0; data_in = '0; dest_in = '0;
    rst_b = 1'b1; valid_in_b = '0; ready_in_b = 1'b0; data_in_b = '0; dest_in_b = '0;
    @(posedge clk); #1;

    applyStimulus(1'b1, 4'b1111, 1'b0, rand_data(), rand_dest());
    checkOutput("reset_data_out", 64'(data_out), 64'd0);
    checkOutput("reset_dest_out", 64'(dest_out), 64'd0);
    checkOutput("reset_src_out", 64'(src_out), 64'd0);
    applyStimulus(1'b1, 4'b1111, 1'b1, rand_data(), rand_dest());
    applyStimulus(1'b0, 4'b1111, 1'b1, rand_data(), rand_dest());

    // Full contention: 0,1,2,3,... one per cycle.
    repeat (12) applyStimulus(1'b0, 4'b1111, 1'b1, rand_data(), rand_dest());

    // Sparse: only sources 1 and 3.
    applyStimulus(1'b1, 4'b0000, 1'b1, rand_data(), rand_dest());
    repeat (8) applyStimulus(1'b0, 4'b1010, 1'b1, rand_data(), rand_dest());

    // Backpressure hold on a known flit from source 2.
    applyStimulus(1'b1, 4'b0000, 1'b1, rand_data(), rand_dest());
    d = rand_data(); a = rand_dest();
    d[2*WIDTH +: WIDTH] = 32'hA5A5_0001;
    a[2*AW +: AW] = 4'd5;
    applyStimulus(1'b0, 4'b0100, 1'b1, d, a);
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 4'b1111, 1'b0, rand_data(), rand_dest());
      checkOutput("bp_data_hold", 64'(data_out), 64'h0000_0000_A5A5_0001);
      checkOutput("bp_dest_hold", 64'(dest_out), 64'd5);
      checkOutput("bp_src_hold", 64'(src_out), 64'd2);
    end
    applyStimulus(1'b0, 4'b0000, 1'b1, rand_data(), rand_dest());
    applyStimulus(1'b0, 4'b0000, 1'b1, rand_data(), rand_dest());
    checkOutput("bp_delivered_once", 64'(sb.size()), 64'd0);

    // Mid-operation reset with a stalled flit.
    applyStimulus(1'b0, 4'b1111, 1'b1, rand_data(), rand_dest());
    applyStimulus(1'b0, 4'b1111, 1'b0, rand_data(), rand_dest());
    applyStimulus(1'b1, 4'b1111, 1'b0, rand_data(), rand_dest());
    applyStimulus(1'b0, 4'b1111, 1'b1, rand_data(), rand_dest());
    applyStimulus(1'b0, 4'b1111, 1'b1, rand_data(), rand_dest());

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      applyStimulus(1'b0, NR'($urandom), ($urandom_range(0, 3) != 0), rand_data(), rand_dest());
    end
    repeat (3) applyStimulus(1'b0, 4'b0000, 1'b1, rand_data(), rand_dest());
    checkOutput("sb_empty_at_end", 64'(sb.size()), 64'd0);

    // Budget instance: 2 sources, BUDGET=3, 2-bit counters.
    rst = 1'b1; valid_in = '0; ready_in = 1'b0;
    @(negedge clk);
    checkOutput("b_reset_ready", 64'(ready_out_b), 64'd0);
    checkOutput("b_reset_done", 64'(done_b), 64'd0);
    @(posedge clk); #1;
    rst_b = 1'b0; valid_in_b = 2'b11; ready_in_b = 1'b1;
    grants_b[0] = 0; grants_b[1] = 0; drains_b = 0; last_b = -1;
    for (int c = 1; c <= 16; c++) begin
      data_in_b = 16'($urandom); dest_in_b = 4'($urandom);
      @(negedge clk);
      for (int i = 0; i < 2; i++) if (ready_out_b[i] && valid_in_b[i]) grants_b[i]++;
      checkOutput("b_ready_onehot", 64'($countones(ready_out_b) <= 1), 64'd1);
      if (valid_out_b && ready_in_b) begin
        drains_b++;
        if (drains_b == 6) last_b = c;
      end
      exp_done = (last_b >= 0) && (c >= last_b + 2);
      checkOutput("b_done", 64'(done_b), 64'(exp_done));
      @(posedge clk); #1;
    end
    checkOutput("b_grants_req0", 64'(grants_b[0]), 64'd3);
    checkOutput("b_grants_req1", 64'(grants_b[1]), 64'd3);
    checkOutput("b_drains", 64'(drains_b), 64'd6);
    checkOutput("b_total_saturated", 64'(total_count_b), 64'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
